// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register feeding decode. Stalls freeze PC and IF/ID;
// a branch redirect loads the target and flushes IF/ID.
// Optional build macro: PERF_CNT_EN adds saturating stall/flush counters.
//
// mode           | meaning
// ---------------+--------------------------------------------------------
// MODE_RUN       | advance PC by 4, capture fetched word into IF/ID
// MODE_STALL     | freeze without branch: PC and IF/ID hold
// MODE_REDIRECT  | branch taken: PC <= aligned target, IF/ID flushed
//
// The mode is decoded from the current inputs only; the sole state is the
// PC and IF/ID registers (plus the optional counters).
module if_stage_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        Branch_taken,
   input  logic [31:0] Branch_Address,
   input  logic [31:0] Instruction_in,
   output logic [31:0] Inst_Addr,
   output logic [31:0] PC_ID,
   output logic [31:0] Instruction_ID,
   output logic        Valid_ID
`ifdef PERF_CNT_EN
   ,
   output logic [15:0] Stall_Count,
   output logic [15:0] Flush_Count
`endif
);

   localparam logic [1:0] MODE_RUN      = 2'd0;
   localparam logic [1:0] MODE_STALL    = 2'd1;
   localparam logic [1:0] MODE_REDIRECT = 2'd2;

   logic [1:0]  mode;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] pc_id_q;
   logic [31:0] instr_id_q;
   logic        valid_id_q;

   // The target's low two bits are dropped to keep the PC word-aligned.
   logic unused_branch_lsbs;
   assign unused_branch_lsbs = ^Branch_Address[1:0];

   assign branch_target = {Branch_Address[31:2], 2'b00};
   assign pc_plus4      = pc_q + 32'd4;

   // Decode the effective mode; a branch wins over a stall because the
   // stalled fetch is discarded anyway.
   always_comb begin
      mode = MODE_RUN;
      if (Branch_taken) begin
         mode = MODE_REDIRECT;
      end else if (freeze) begin
         mode = MODE_STALL;
      end
   end

   // Program counter update.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         case (mode)
            MODE_REDIRECT: pc_q <= branch_target;
            MODE_STALL:    pc_q <= pc_q;
            default:       pc_q <= pc_plus4;
         endcase
      end
   end

   // IF/ID pipeline register: flush on reset or redirect, hold on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_id_q    <= 32'h0000_0000;
         instr_id_q <= NOP_INSTR;
         valid_id_q <= 1'b0;
      end else begin
         case (mode)
            MODE_REDIRECT: begin
               pc_id_q    <= 32'h0000_0000;
               instr_id_q <= NOP_INSTR;
               valid_id_q <= 1'b0;
            end
            MODE_STALL: begin
               pc_id_q    <= pc_id_q;
               instr_id_q <= instr_id_q;
               valid_id_q <= valid_id_q;
            end
            default: begin
               pc_id_q    <= pc_plus4;
               instr_id_q <= Instruction_in;
               valid_id_q <= 1'b1;
            end
         endcase
      end
   end

   assign Inst_Addr      = pc_q;
   assign PC_ID          = pc_id_q;
   assign Instruction_ID = instr_id_q;
   assign Valid_ID       = valid_id_q;

`ifdef PERF_CNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // Saturating event counters; cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         if (mode == MODE_STALL && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (mode == MODE_REDIRECT && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign Stall_Count = stall_cnt_q;
   assign Flush_Count = flush_cnt_q;
`endif

endmodule
